// File: rtl/multiciclo.sv
// Multicycle RV32I subset core with a single unified memory port.
// Optional RV32M mul (shift-add, 32 cycles) compiled in by defining MULTICICLO_MUL_EN.
module multiciclo #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    output logic              oMemReq,
    output logic              oMemWE,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [31:0]       oMemWData,
    input  logic              iMemReady,
    input  logic [31:0]       iMemRData,
    input  logic [4:0]        iRegDispSelect,
    output logic [31:0]       oRegDisp,
    output logic [31:0]       oPC,
    output logic [31:0]       oInstr,
    output logic [2:0]        oState,
    output logic              oIllegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        MUL    = 3'd5,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    state_t              state;
    logic [31:0]         pc, old_pc, ir, a, b, imm, alu_out, mdr;
    logic [31:0]         regs [32];
    logic                mem_req, mem_we, illegal;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_opimm, is_op;
    logic        base_legal, legal, taken;
    logic [31:0] imm_dec, alu_b, alu_res, addr_sum, link, br_target, pc_plus4, wb_data;
    logic [31:0] rs1_val, rs2_val;

`ifdef MULTICICLO_MUL_EN
    logic        is_mul;
    logic [31:0] mcand, mplier, acc, acc_next;
    logic [4:0]  mul_cnt;
`endif

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign is_load   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    assign is_store  = (opcode == OP_STORE)  && (funct3 == 3'b010);
    assign is_branch = (opcode == OP_BRANCH) && (funct3 inside {3'b000, 3'b001});
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR)   && (funct3 == 3'b000);
    assign is_lui    = (opcode == OP_LUI);
    assign is_opimm  = (opcode == OP_IMM)    && (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
    assign is_op     = (opcode == OP_REG) &&
                       (((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111})) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    assign base_legal = is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_opimm | is_op;

`ifdef MULTICICLO_MUL_EN
    assign is_mul   = (opcode == OP_REG) && (funct7 == 7'b0000001) && (funct3 == 3'b000);
    assign legal    = base_legal | is_mul;
    assign acc_next = acc + (mplier[0] ? mcand : 32'd0);
`else
    assign legal = base_legal;
`endif

    assign rs1_val   = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val   = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign addr_sum  = a + imm;
    assign link      = old_pc + 32'd4;
    assign br_target = old_pc + imm;
    assign pc_plus4  = pc + 32'd4;
    assign taken     = (a == b) ^ funct3[0];
    assign wb_data   = is_load ? mdr : alu_out;

    assign oMemReq   = mem_req;
    assign oMemWE    = mem_we;
    assign oMemAddr  = mem_addr;
    assign oMemWData = mem_wdata;
    assign oPC       = pc;
    assign oInstr    = ir;
    assign oState    = state;
    assign oIllegal  = illegal;
    assign oRegDisp  = (iRegDispSelect == 5'd0) ? '0 : regs[iRegDispSelect];

    // Immediate extraction by instruction format
    always_comb begin
        imm_dec = {{20{ir[31]}}, ir[31:20]};
        if (is_store)
            imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        else if (is_branch)
            imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        else if (is_jal)
            imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        else if (is_lui)
            imm_dec = {ir[31:12], 12'b0};
    end

    // ALU for register/immediate arithmetic; load/store/jalr use addr_sum instead
    always_comb begin
        alu_b   = is_op ? b : imm;
        alu_res = a + alu_b;
        case (funct3)
            3'b000:  alu_res = (is_op && funct7[5]) ? (a - alu_b) : (a + alu_b);
            3'b010:  alu_res = {31'b0, $signed(a) < $signed(alu_b)};
            3'b110:  alu_res = a | alu_b;
            3'b111:  alu_res = a & alu_b;
            default: alu_res = a + alu_b;
        endcase
    end

    // Control FSM, datapath registers and register file
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            old_pc    <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            imm       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            illegal   <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
`ifdef MULTICICLO_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_cnt <= '0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // Entering FETCH normally raises the request; after reset it is raised here
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc[ADDR_W-1:0];
                    end else if (iMemReady) begin
                        ir      <= iMemRData;
                        old_pc  <= pc;
                        pc      <= pc_plus4;
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a   <= rs1_val;
                    b   <= rs2_val;
                    imm <= imm_dec;
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= TRAP;
                    end
                end
                EXEC: begin
                    if (is_branch) begin
                        if (taken) pc <= br_target;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= taken ? br_target[ADDR_W-1:0] : pc[ADDR_W-1:0];
                        state    <= FETCH;
                    end else if (is_load || is_store) begin
                        alu_out <= addr_sum;
                        if (addr_sum[1:0] != 2'b00) begin
                            illegal <= 1'b1;
                            state   <= TRAP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= addr_sum[ADDR_W-1:0];
                            mem_wdata <= b;
                            state     <= MEM;
                        end
                    end else if (is_jal) begin
                        pc      <= br_target;
                        alu_out <= link;
                        state   <= WB;
                    end else if (is_jalr) begin
                        pc      <= {addr_sum[31:1], 1'b0};
                        alu_out <= link;
                        state   <= WB;
                    end else if (is_lui) begin
                        alu_out <= imm;
                        state   <= WB;
`ifdef MULTICICLO_MUL_EN
                    end else if (is_mul) begin
                        mcand   <= a;
                        mplier  <= b;
                        acc     <= '0;
                        mul_cnt <= '0;
                        state   <= MUL;
`endif
                    end else begin
                        alu_out <= alu_res;
                        state   <= WB;
                    end
                end
                MEM: begin
                    // A store hands the port straight over to the next fetch
                    if (iMemReady) begin
                        mem_we <= 1'b0;
                        if (is_load) begin
                            mdr     <= iMemRData;
                            mem_req <= 1'b0;
                            state   <= WB;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc[ADDR_W-1:0];
                            state    <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (rd != 5'd0) regs[rd] <= wb_data;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc[ADDR_W-1:0];
                    state    <= FETCH;
                end
                MUL: begin
`ifdef MULTICICLO_MUL_EN
                    acc     <= acc_next;
                    mcand   <= {mcand[30:0], 1'b0};
                    mplier  <= {1'b0, mplier[31:1]};
                    mul_cnt <= mul_cnt + 5'd1;
                    if (mul_cnt == 5'd31) begin
                        alu_out <= acc_next;
                        state   <= WB;
                    end
`else
                    mem_req <= 1'b0;
                    state   <= FETCH;
`endif
                end
                TRAP: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiciclo.sv
// Directed-vector bench for multiciclo with a stall-programmable memory model.
// Define MULTICICLO_MUL_EN for both bench and design to exercise the mul path.
module tb_multiciclo;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        oMemReq, oMemWE;
    logic [31:0] oMemAddr, oMemWData;
    logic        iMemReady = 1'b0;
    logic [31:0] iMemRData = '0;
    logic [4:0]  iRegDispSelect = '0;
    logic [31:0] oRegDisp, oPC, oInstr;
    logic [2:0]  oState;
    logic        oIllegal;

    multiciclo #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .oMemReq(oMemReq), .oMemWE(oMemWE), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .iMemReady(iMemReady), .iMemRData(iMemRData),
        .iRegDispSelect(iRegDispSelect), .oRegDisp(oRegDisp),
        .oPC(oPC), .oInstr(oInstr), .oState(oState), .oIllegal(oIllegal)
    );

    initial forever #5 iCLK = ~iCLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned stall_n  = 0;
    int unsigned stall_cnt = 0;
    logic [31:0] code_mem [16];
    logic [31:0] data_mem [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - RESET_PC;
        if (addr >= RESET_PC) return code_mem[off[5:2]];
        return data_mem[addr[5:2]];
    endfunction

    // Memory responder: decides ready for the coming edge, presents read data, commits stores
    initial forever begin
        @(negedge iCLK);
        if (oMemReq) begin
            iMemRData = mem_read(oMemAddr);
            if (stall_cnt < stall_n) begin
                iMemReady = 1'b0;
                stall_cnt++;
            end else begin
                iMemReady = 1'b1;
                stall_cnt = 0;
                if (oMemWE && oMemAddr < RESET_PC) data_mem[oMemAddr[5:2]] = oMemWData;
            end
        end else begin
            iMemReady = (stall_n == 0);
            stall_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            code_mem[i] = 32'h0000_0000;
            data_mem[i] = 32'h0000_0000;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic reg_is(input string tag, input logic [4:0] r, input logic [31:0] exp);
        iRegDispSelect = r;
        #1;
        check(tag, oRegDisp, exp);
    endtask

    task automatic hold_reset();
        iRST_N = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
    endtask

    task automatic release_reset();
        @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    task automatic load_prog_ab();
        clear_mem();
        code_mem[0] = 32'h0070_0293; // addi x5,x0,7
        code_mem[1] = 32'h0052_8333; // add  x6,x5,x5
        code_mem[2] = 32'h0060_2023; // sw   x6,0(x0)
        code_mem[3] = 32'h0000_2383; // lw   x7,0(x0)
        code_mem[4] = 32'hFE00_0CE3; // beq  x0,x0,-8
    endtask

    initial begin
        // Run A: no stalls, reset values, ALU, store/load, taken branch
        load_prog_ab();
        stall_n = 0;
        hold_reset();
        check("rst_pc", oPC, RESET_PC);
        check("rst_state", {29'b0, oState}, 32'd0);
        check("rst_req", {31'b0, oMemReq}, 32'd0);
        check("rst_we", {31'b0, oMemWE}, 32'd0);
        check("rst_illegal", {31'b0, oIllegal}, 32'd0);
        check("rst_ir", oInstr, 32'd0);
        reg_is("rst_x5", 5'd5, 32'd0);
        release_reset();
        step(1);
        check("first_req", {31'b0, oMemReq}, 32'd1);
        check("first_addr", oMemAddr, RESET_PC);
        check("first_we", {31'b0, oMemWE}, 32'd0);
        step(1);
        check("a_decode_state", {29'b0, oState}, 32'd1);
        check("a_pc_after_fetch", oPC, RESET_PC + 32'd4);
        check("a_ir", oInstr, 32'h0070_0293);
        check("a_req_drop", {31'b0, oMemReq}, 32'd0);
        step(1);
        check("a_exec_state", {29'b0, oState}, 32'd2);
        step(1);
        check("a_wb_state", {29'b0, oState}, 32'd4);
        step(1);
        reg_is("a_x5", 5'd5, 32'd7);
        step(4);
        check("a_pc_8", oPC, RESET_PC + 32'd8);
        reg_is("a_x6", 5'd6, 32'd14);
        step(4);
        check("a_stored", data_mem[0], 32'd14);
        step(5);
        reg_is("a_x7", 5'd7, 32'd14);
        step(1);
        check("a_pc_beq_fetch", oPC, RESET_PC + 32'h14);
        step(2);
        check("a_beq_pc", oPC, 32'h0040_0008);
        check("a_beq_state", {29'b0, oState}, 32'd0);
        check("a_beq_addr", oMemAddr, 32'h0040_0008);

        // Run B: three stall cycles per request
        load_prog_ab();
        stall_n = 3;
        hold_reset();
        release_reset();
        step(1);
        check("b_req", {31'b0, oMemReq}, 32'd1);
        step(1);
        check("b_stall_state", {29'b0, oState}, 32'd0);
        check("b_stall_addr1", oMemAddr, RESET_PC);
        step(2);
        check("b_stall_addr3", oMemAddr, RESET_PC);
        check("b_stall_pc", oPC, RESET_PC);
        step(1);
        check("b_decode", {29'b0, oState}, 32'd1);
        step(16);
        check("b_sw_state", {29'b0, oState}, 32'd3);
        check("b_sw_we", {31'b0, oMemWE}, 32'd1);
        check("b_sw_addr", oMemAddr, 32'd0);
        check("b_sw_wdata", oMemWData, 32'd14);
        step(2);
        check("b_sw_state2", {29'b0, oState}, 32'd3);
        check("b_sw_addr2", oMemAddr, 32'd0);
        check("b_sw_wdata2", oMemWData, 32'd14);
        step(2);
        check("b_after_sw_state", {29'b0, oState}, 32'd0);
        check("b_after_sw_we", {31'b0, oMemWE}, 32'd0);
        check("b_after_sw_addr", oMemAddr, RESET_PC + 32'd12);
        step(11);
        reg_is("b_x7", 5'd7, 32'd14);
        check("b_pc", oPC, RESET_PC + 32'd16);
        check("b_pending_req", {31'b0, oMemReq}, 32'd1);
        #1;
        iRST_N = 1'b0;
        #1;
        check("b_async_req", {31'b0, oMemReq}, 32'd0);
        check("b_async_state", {29'b0, oState}, 32'd0);
        check("b_async_pc", oPC, RESET_PC);
        reg_is("b_async_x7", 5'd7, 32'd0);

        // Run C: jal, x0 write, untaken bne, misaligned load trap, reset out of trap
        clear_mem();
        code_mem[0] = 32'h0100_00EF; // jal  x1,+16
        code_mem[4] = 32'h0050_0013; // addi x0,x0,5
        code_mem[5] = 32'h0000_1463; // bne  x0,x0,+8
        code_mem[6] = 32'h0020_2403; // lw   x8,2(x0)
        stall_n = 0;
        hold_reset();
        release_reset();
        step(5);
        check("c_jal_pc", oPC, 32'h0040_0010);
        reg_is("c_jal_x1", 5'd1, 32'h0040_0004);
        step(4);
        reg_is("c_x0", 5'd0, 32'd0);
        step(3);
        check("c_bne_pc", oPC, 32'h0040_0018);
        check("c_bne_state", {29'b0, oState}, 32'd0);
        check("c_bne_addr", oMemAddr, 32'h0040_0018);
        step(3);
        check("c_trap_illegal", {31'b0, oIllegal}, 32'd1);
        check("c_trap_state", {29'b0, oState}, 32'd7);
        check("c_trap_req", {31'b0, oMemReq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("c_trap_hold_req", {31'b0, oMemReq}, 32'd0);
            check("c_trap_hold_state", {29'b0, oState}, 32'd7);
        end
        check("c_trap_pc", oPC, 32'h0040_001C);
        reg_is("c_trap_x1", 5'd1, 32'h0040_0004);
        reg_is("c_trap_x8", 5'd8, 32'd0);
        iRST_N = 1'b0;
        #1;
        check("c_rst_illegal", {31'b0, oIllegal}, 32'd0);
        check("c_rst_state", {29'b0, oState}, 32'd0);
        check("c_rst_pc", oPC, RESET_PC);
        reg_is("c_rst_x1", 5'd1, 32'd0);

        // Run D: mul x7,x5,x6 with x5=-1, x6=3
        clear_mem();
        code_mem[0] = 32'hFFF0_0293; // addi x5,x0,-1
        code_mem[1] = 32'h0030_0313; // addi x6,x0,3
        code_mem[2] = 32'h0262_83B3; // mul  x7,x5,x6
        hold_reset();
        release_reset();
        step(9);
        reg_is("d_x5", 5'd5, 32'hFFFF_FFFF);
        reg_is("d_x6", 5'd6, 32'd3);
        step(3);
`ifdef MULTICICLO_MUL_EN
        check("d_mul_enter", {29'b0, oState}, 32'd5);
        step(31);
        check("d_mul_last", {29'b0, oState}, 32'd5);
        step(1);
        check("d_mul_wb", {29'b0, oState}, 32'd4);
        step(1);
        reg_is("d_x7", 5'd7, 32'hFFFF_FFFD);
        check("d_illegal", {31'b0, oIllegal}, 32'd0);
`else
        check("d_mul_trap", {29'b0, oState}, 32'd7);
        check("d_mul_illegal", {31'b0, oIllegal}, 32'd1);
        step(2);
        reg_is("d_x7", 5'd7, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
